swd_target: RTL and testbench

- SWD target-side (responder) serialiser/deserialiser; the counterpart of the host SWD interface.
- Sits between the SWD pins and a DP/AP register model.
- Decodes 8-bit request headers, drives ACK and read data with parity, captures write data, detects line resets.
- Used for loopback/self-test of the host engine and for target emulation.

---
 rtl/swd_pkg.sv | 22 ++
 rtl/swd_linereset_det.sv | 24 ++
 rtl/swd_target.sv | 162 ++++++++++++++++
 tb/tb_swd_target.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/swd_pkg.sv
// swd_pkg: SWD state encodings, ACK codes, frame positions and header parity shared by host and target
package swd_pkg;
  typedef enum logic [3:0] {
    ST_LOCKOUT = 4'd0,
    ST_IDLE    = 4'd1,
    ST_HDR     = 4'd2,
    ST_TRN1    = 4'd3,
    ST_ACK     = 4'd4,
    ST_DATA_TX = 4'd5,
    ST_TRN2    = 4'd6,
    ST_DATA_RX = 4'd7,
    ST_TRN3    = 4'd8
  } st_e;
  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;
  localparam int HDR_END   = 7;
  localparam int DATA_BITS = 32;
  function automatic logic hdr_parity(input logic apndp, input logic rnw, input logic a2, input logic a3);
    return apndp ^ rnw ^ a2 ^ a3;
  endfunction
endpackage

// File: rtl/swd_linereset_det.sv
// swd_linereset_det: saturating count of consecutive sampled ones with a single line-reset pulse
module swd_linereset_det #(
  parameter int LRST_BITS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic hit,
  output logic line_reset
);
  localparam int W = $clog2(LRST_BITS + 1);
  logic [W-1:0] cnt;
  assign hit = en & din & (cnt == W'(LRST_BITS - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      line_reset <= 1'b0;
    end else begin
      line_reset <= hit;
      if (en) cnt <= !din ? '0 : (cnt == W'(LRST_BITS)) ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/swd_target.sv
// swd_target: SWD target-side serialiser/deserialiser between SWD pins and a DP/AP register model
module swd_target
  import swd_pkg::*;
#(
  parameter int TURN      = 1,
  parameter int LRST_BITS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rising,
  input  logic        falling,
  input  logic        swdi,
  output logic        swdo,
  output logic        swwr,
  output logic        req_valid,
  output logic        req_apndp,
  output logic        req_rnw,
  output logic [1:0]  req_addr32,
  input  logic [2:0]  ack_resp,
  input  logic [31:0] rdata,
  output logic        wr_valid,
  output logic [31:0] wdata,
  output logic        wr_perr,
  output logic        line_reset
);
  typedef struct packed {
    st_e         state;
    logic [5:0]  bc;
    logic [5:0]  hs;
    logic [2:0]  ack;
    logic [31:0] rd;
    logic [31:0] sh;
    logic        par;
    logic        swdo;
    logic        swwr;
    logic        armed;
    logic        req_valid;
    logic        apndp;
    logic        rnw;
    logic [1:0]  addr;
    logic        wr_valid;
    logic [31:0] wdata;
    logic        wr_perr;
  } regs_t;
  regs_t r, n;
  logic hit;
  logic unused_falling;
  assign unused_falling = falling;
  swd_linereset_det #(.LRST_BITS(LRST_BITS)) u_lrst (
    .clk(clk),
    .rst(rst),
    .en(rising & ~r.swwr),
    .din(swdi),
    .hit(hit),
    .line_reset(line_reset)
  );
  always_comb begin
    n = r;
    n.req_valid = 1'b0;
    n.wr_valid = 1'b0;
    if (rising && hit) begin
      n.state = ST_LOCKOUT;
      n.armed = 1'b1;
      n.swdo = 1'b0;
      n.swwr = 1'b0;
    end else if (rising) begin
      case (r.state)
        ST_LOCKOUT: if (r.armed && !swdi) begin
          n.state = ST_IDLE;
          n.armed = 1'b0;
        end
        ST_IDLE: if (swdi) begin
          n.state = ST_HDR;
          n.bc = 6'd1;
        end
        ST_HDR: if (r.bc != 6'(HDR_END)) begin
          n.hs = {swdi, r.hs[5:1]};
          n.bc = r.bc + 6'd1;
        end else if (!r.hs[5] && swdi && r.hs[4] == hdr_parity(r.hs[0], r.hs[1], r.hs[2], r.hs[3])) begin
          n.req_valid = 1'b1;
          n.apndp = r.hs[0];
          n.rnw = r.hs[1];
          n.addr = {r.hs[3], r.hs[2]};
          n.state = ST_TRN1;
          n.bc = '0;
        end else begin
          n.state = ST_LOCKOUT;
        end
        ST_TRN1: if (r.bc == 6'(TURN - 1)) begin
          n.ack = ack_resp;
          n.rd = rdata;
          n.swwr = 1'b1;
          n.swdo = ack_resp[0];
          n.state = ST_ACK;
          n.bc = 6'd1;
        end else begin
          n.bc = r.bc + 6'd1;
        end
        ST_ACK: if (r.bc != 6'd3) begin
          n.swdo = r.ack[r.bc[1:0]];
          n.bc = r.bc + 6'd1;
        end else if (r.ack == ACK_OK && r.rnw) begin
          n.swdo = r.rd[0];
          n.state = ST_DATA_TX;
          n.bc = 6'd1;
        end else begin
          n.swdo = 1'b0;
          n.swwr = 1'b0;
          n.state = ST_TRN2;
          n.bc = '0;
        end
        ST_DATA_TX: if (r.bc < 6'(DATA_BITS)) begin
          n.swdo = r.rd[r.bc[4:0]];
          n.bc = r.bc + 6'd1;
        end else if (r.bc == 6'(DATA_BITS)) begin
          n.swdo = ^r.rd;
          n.bc = r.bc + 6'd1;
        end else begin
          n.swdo = 1'b0;
          n.swwr = 1'b0;
          n.state = ST_TRN3;
          n.bc = '0;
        end
        ST_TRN2: if (r.bc == 6'(TURN - 1)) begin
          n.state = (r.ack == ACK_OK && !r.rnw) ? ST_DATA_RX : ST_IDLE;
          n.bc = '0;
          n.par = 1'b0;
        end else begin
          n.bc = r.bc + 6'd1;
        end
        ST_TRN3: begin
          n.state = (r.bc == 6'(TURN - 1)) ? ST_IDLE : ST_TRN3;
          n.bc = (r.bc == 6'(TURN - 1)) ? '0 : r.bc + 6'd1;
        end
        ST_DATA_RX: if (r.bc != 6'(DATA_BITS)) begin
          n.sh = {swdi, r.sh[31:1]};
          n.par = r.par ^ swdi;
          n.bc = r.bc + 6'd1;
        end else begin
          n.wdata = r.sh;
          n.wr_perr = r.par ^ swdi;
          n.wr_valid = 1'b1;
          n.state = ST_IDLE;
        end
        default: n.state = ST_LOCKOUT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else r <= n;
  end
  assign swdo = r.swdo;
  assign swwr = r.swwr;
  assign req_valid = r.req_valid;
  assign req_apndp = r.apndp;
  assign req_rnw = r.rnw;
  assign req_addr32 = r.addr;
  assign wr_valid = r.wr_valid;
  assign wdata = r.wdata;
  assign wr_perr = r.wr_perr;
endmodule

// File: tb/tb_swd_target.sv
// tb_swd_target: directed table-driven check of the SWD target responder
module tb_swd_target;
  localparam int T = 2;
  logic clk = 1'b0, rst = 1'b1, rising = 1'b0, falling = 1'b0, swdi = 1'b0;
  logic swdo, swwr, req_valid, req_apndp, req_rnw, wr_valid, wr_perr, line_reset;
  logic [1:0] req_addr32;
  logic [2:0] ack_resp = 3'b000;
  logic [31:0] rdata = 32'h0, wdata;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0]  hdr;
    logic [2:0]  ack;
    logic [31:0] data;
    logic        par;
    logic        pflip;
    logic        e_ap;
    logic        e_rnw;
    logic [1:0]  e_addr;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  swd_target #(.TURN(T), .LRST_BITS(50)) dut (
    .clk(clk),
    .rst(rst),
    .rising(rising),
    .falling(falling),
    .swdi(swdi),
    .swdo(swdo),
    .swwr(swwr),
    .req_valid(req_valid),
    .req_apndp(req_apndp),
    .req_rnw(req_rnw),
    .req_addr32(req_addr32),
    .ack_resp(ack_resp),
    .rdata(rdata),
    .wr_valid(wr_valid),
    .wdata(wdata),
    .wr_perr(wr_perr),
    .line_reset(line_reset)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input logic b);
    @(negedge clk);
    swdi = b;
    rising = 1'b1;
    falling = 1'b0;
    @(negedge clk);
    rising = 1'b0;
    falling = 1'b1;
  endtask
  task automatic send_quiet(input logic [7:0] h, input int extra, output logic rv, output logic drv);
    rv = 1'b0;
    drv = 1'b0;
    for (int i = 0; i < 8 + extra; i++) begin
      tick(i < 8 ? h[i] : 1'b0);
      rv |= req_valid;
      drv |= swwr;
    end
  endtask
  task automatic lrst(input string nm);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      if (i < 49) early |= line_reset;
    end
    chk({nm, " line_reset"}, 64'({early, line_reset}), 64'(2'b01));
    tick(1'b1);
    chk({nm, " no repeat"}, 64'(line_reset), 64'(0));
    tick(1'b0);
  endtask
  task automatic xact(input vec_t v, input int id);
    logic [31:0] got;
    logic [2:0] ga;
    logic rv, drv, quiet;
    string p;
    p = $sformatf("v%0d", id);
    ack_resp = v.ack;
    rdata = v.data;
    rv = 1'b0;
    quiet = 1'b1;
    drv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(v.hdr[i]);
      if (i < 7) rv |= req_valid;
      quiet &= ~swwr;
    end
    chk({p, " req_valid"}, 64'({rv, req_valid}), 64'(2'b01));
    chk({p, " req fields"}, 64'({req_apndp, req_rnw, req_addr32}), 64'({v.e_ap, v.e_rnw, v.e_addr}));
    for (int i = 0; i < T - 1; i++) begin
      tick(1'b0);
      quiet &= ~swwr;
    end
    chk({p, " turnaround quiet"}, 64'(quiet), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      ga[i] = swdo;
      drv &= swwr;
    end
    chk({p, " ack bits"}, 64'({drv, ga}), 64'({1'b1, v.ack}));
    if (v.ack == 3'b001 && v.e_rnw) begin
      for (int i = 0; i < 32; i++) begin
        tick(1'b0);
        got[i] = swdo;
        drv &= swwr;
      end
      chk({p, " rdata"}, 64'({drv, got}), 64'({1'b1, v.data}));
      tick(1'b0);
      chk({p, " rparity"}, 64'({swwr, swdo}), 64'({1'b1, v.par}));
      tick(1'b0);
      chk({p, " release"}, 64'({swwr, swdo}), 64'(0));
      for (int i = 0; i < T; i++) begin
        tick(1'b0);
        quiet &= ~swwr;
      end
    end else begin
      tick(1'b0);
      chk({p, " release"}, 64'({swwr, swdo}), 64'(0));
      for (int i = 0; i < T; i++) begin
        tick(1'b0);
        quiet &= ~swwr;
      end
      if (v.ack == 3'b001) begin
        rv = 1'b0;
        for (int i = 0; i < 32; i++) begin
          tick(v.data[i]);
          quiet &= ~swwr;
          rv |= wr_valid;
        end
        tick(v.par ^ v.pflip);
        chk({p, " write"}, 64'({rv, wr_valid, wr_perr, wdata}), 64'({1'b0, 1'b1, v.pflip, v.data}));
      end
    end
    tick(1'b0);
    chk({p, " tail quiet"}, 64'({quiet, swwr, wr_valid}), 64'(3'b100));
  endtask
  initial begin
    logic rv, drv;
    vecs[0] = '{8'hA5, 3'b001, 32'h2BA01477, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{8'h8B, 3'b001, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[2] = '{8'h8B, 3'b001, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[3] = '{8'hA5, 3'b010, 32'h2BA01477, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[4] = '{8'h9F, 3'b001, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
    vecs[5] = '{8'h8B, 3'b100, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[6] = '{8'hB1, 3'b001, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[7] = '{8'h95, 3'b001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'({swwr, swdo, req_valid, wr_valid, wr_perr, line_reset, req_apndp, req_rnw, req_addr32}), 64'(0));
    chk("reset wdata", 64'(wdata), 64'(0));
    rst = 1'b0;
    send_quiet(8'hA5, T + 4, rv, drv);
    chk("lockout after reset", 64'({rv, drv}), 64'(0));
    lrst("first");
    tick(1'b0);
    for (int i = 0; i < 8; i++) xact(vecs[i], i);
    send_quiet(8'hE5, 0, rv, drv);
    chk("bad stop bit", 64'({rv, drv}), 64'(0));
    send_quiet(8'hA5, T + 4, rv, drv);
    chk("header after bad stop", 64'({rv, drv}), 64'(0));
    lrst("after bad hdr");
    xact(vecs[0], 10);
    ack_resp = 3'b001;
    rdata = 32'h2BA01477;
    for (int i = 0; i < 8; i++) tick(vecs[0].hdr[i]);
    for (int i = 0; i < T + 2; i++) tick(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0);
    chk("driving before rst", 64'(swwr), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid data", 64'({swwr, swdo, req_valid, wr_valid, line_reset}), 64'(0));
    rst = 1'b0;
    send_quiet(8'hA5, T + 4, rv, drv);
    chk("lockout after mid rst", 64'({rv, drv}), 64'(0));
    lrst("after mid rst");
    xact(vecs[1], 11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
